// File: rtl/mcdt_nchnl.sv
// ----------------------------------------------------------------------------
// mcdt_nchnl - parametrised multi-channel data transfer block
//
// Each of N_CH input channels writes through a valid/ready port into its own
// FIFO. A single arbiter drains one word per cycle from the non-empty FIFOs
// onto a tagged output stream (data, valid, source channel id).
//
// Build option:
//   MCDT_FIXED_PRIO_EN  undefined (default): round-robin grant, starting at
//                       ch0 after reset.
//                       defined: fixed priority, where the lowest non-empty
//                       channel index always wins.
//
// Ports:
//   clk          in   clock; all logic on posedge
//   rstn         in   asynchronous reset, active-high
//   ch_data_i    in   N_CH*DW  write data, channel k at [k*DW +: DW]
//   ch_valid_i   in   N_CH     write valid per channel
//   ch_ready_o   out  N_CH     channel FIFO not full
//   ch_margin_o  out  N_CH*MW  free FIFO slots, channel k at [k*MW +: MW]
//   mcdt_data_o  out  DW       output word (holds its value when idle)
//   mcdt_val_o   out  1        output word valid (one-cycle pulse per word)
//   mcdt_id_o    out  IDW      source channel of mcdt_data_o
// ----------------------------------------------------------------------------
module mcdt_nchnl #(
  parameter  int N_CH  = 3,
  parameter  int DW    = 32,
  parameter  int DEPTH = 32,
  localparam int MW    = $clog2(DEPTH + 1),
  localparam int IDW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_CH*DW-1:0] ch_data_i,
  input  logic [N_CH-1:0]    ch_valid_i,
  output logic [N_CH-1:0]    ch_ready_o,
  output logic [N_CH*MW-1:0] ch_margin_o,
  output logic [DW-1:0]      mcdt_data_o,
  output logic               mcdt_val_o,
  output logic [IDW-1:0]     mcdt_id_o
);

  localparam int AW = $clog2(DEPTH);

  logic [N_CH-1:0] w_cand;           // channel FIFO non-empty
  logic [N_CH-1:0] w_push;
  logic [N_CH-1:0] w_pop;
  logic [DW-1:0]   w_head [N_CH];    // word at each FIFO's read pointer
  logic            w_gnt_vld;
  logic [IDW-1:0]  w_gnt_id;
  logic [DW-1:0]   w_out_data;

  logic [DW-1:0]   r_data;
  logic            r_val;
  logic [IDW-1:0]  r_id;

  // --------------------------------------------------------------------------
  // Per-channel FIFOs
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [MW-1:0] r_cnt;

    // Flow control comes straight from the registered count.
    assign ch_ready_o[k]            = (r_cnt != MW'(DEPTH));
    assign ch_margin_o[k*MW +: MW]  = MW'(DEPTH) - r_cnt;
    assign w_push[k]                = ch_valid_i[k] & ch_ready_o[k];
    assign w_cand[k]                = (r_cnt != '0);
    assign w_pop[k]                 = w_gnt_vld && (w_gnt_id == IDW'(k));
    assign w_head[k]                = r_mem[r_rd_ptr];

    // NOTE: storage has no reset; the cleared count and pointers already mark
    // every entry invalid, and leaving it out keeps the array a plain RAM.
    always_ff @(posedge clk) begin
      if (w_push[k]) r_mem[r_wr_ptr] <= ch_data_i[k*DW +: DW];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (w_push[k]) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop[k])  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt <= r_cnt + MW'(1);
          2'b01:   r_cnt <= r_cnt - MW'(1);
          default: r_cnt <= r_cnt;   // idle, or push and pop together
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign w_gnt_vld = |w_cand;

`ifdef MCDT_FIXED_PRIO_EN
  // Lowest non-empty index wins; scanning downward lets it overwrite.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_gnt_id = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_cand[k]) w_gnt_id = IDW'(k);
    end
  end
`else
  logic [IDW-1:0] r_rr_ptr;   // last granted channel
  logic           w_hi_vld;
  logic [IDW-1:0] w_hi_id;
  logic [IDW-1:0] w_lo_id;

  // Round-robin: the lowest candidate above the last grant wins; if there is
  // none, wrap and take the lowest candidate at or below it.
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_id  = '0;
    w_lo_id  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_cand[k]) begin
        if (k > int'(r_rr_ptr)) begin
          w_hi_vld = 1'b1;
          w_hi_id  = IDW'(k);
        end else begin
          w_lo_id  = IDW'(k);
        end
      end
    end
    w_gnt_id = w_hi_vld ? w_hi_id : w_lo_id;
  end

  // Reset to the last channel so ch0 is granted first.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)           r_rr_ptr <= IDW'(N_CH - 1);
    else if (w_gnt_vld) r_rr_ptr <= w_gnt_id;
  end
`endif

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  always_comb begin
    w_out_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_pop[k]) w_out_data = w_head[k];
    end
  end

  // Data and id hold their last values while no channel is granted.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_val  <= 1'b0;
      r_data <= '0;
      r_id   <= '0;
    end else begin
      r_val <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_data <= w_out_data;
        r_id   <= w_gnt_id;
      end
    end
  end

  assign mcdt_val_o  = r_val;
  assign mcdt_data_o = r_data;
  assign mcdt_id_o   = r_id;

endmodule

// File: tb/tb_mcdt_nchnl.sv
// ----------------------------------------------------------------------------
// tb_mcdt_nchnl - directed self-checking bench for mcdt_nchnl
//
// u_dut : default build (N_CH=3, DW=32, DEPTH=32), round-robin arbitration.
// u_small : N_CH=1, DW=8, DEPTH=4.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point, away from the active edge.
// ----------------------------------------------------------------------------
module tb_mcdt_nchnl;

  logic        clk = 1'b0;
  logic        rstn;

  // 3-channel instance
  logic [95:0] ch_data;
  logic [2:0]  ch_valid;
  logic [2:0]  ch_ready;
  logic [17:0] ch_margin;
  logic [31:0] dout;
  logic        dval;
  logic [1:0]  did;

  // 1-channel instance
  logic [7:0]  s_data;
  logic [0:0]  s_valid;
  logic [0:0]  s_ready;
  logic [2:0]  s_margin;
  logic [7:0]  s_dout;
  logic        s_dval;
  logic [0:0]  s_did;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mcdt_nchnl #(.N_CH(3), .DW(32), .DEPTH(32)) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .ch_data_i   (ch_data),
    .ch_valid_i  (ch_valid),
    .ch_ready_o  (ch_ready),
    .ch_margin_o (ch_margin),
    .mcdt_data_o (dout),
    .mcdt_val_o  (dval),
    .mcdt_id_o   (did)
  );

  mcdt_nchnl #(.N_CH(1), .DW(8), .DEPTH(4)) u_small (
    .clk         (clk),
    .rstn        (rstn),
    .ch_data_i   (s_data),
    .ch_valid_i  (s_valid),
    .ch_ready_o  (s_ready),
    .ch_margin_o (s_margin),
    .mcdt_data_o (s_dout),
    .mcdt_val_o  (s_dval),
    .mcdt_id_o   (s_did)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A single channel streams n words back to back while the others stay idle.
  // Each word appears on the output one cycle after it is accepted, and the
  // FIFO holds exactly one word throughout.
  task automatic stream(input int ch, input logic [31:0] base, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      ch_data[ch*32 +: 32] = base + 32'(i);
      ch_valid[ch]         = 1'b1;
      tick();
      check({tag, " margin"}, 64'(ch_margin[ch*6 +: 6]), 64'd31);
      check({tag, " ready"},  64'(ch_ready), 64'b111);
      if (i == 0) begin
        check({tag, " first val"}, 64'(dval), 64'd0);
      end else begin
        check({tag, " val"},  64'(dval), 64'd1);
        check({tag, " data"}, 64'(dout), 64'(base + 32'(i - 1)));
        check({tag, " id"},   64'(did),  64'(ch));
      end
    end
    ch_valid[ch] = 1'b0;
    tick();
    check({tag, " last val"},  64'(dval), 64'd1);
    check({tag, " last data"}, 64'(dout), 64'(base + 32'(n - 1)));
    check({tag, " empty margin"}, 64'(ch_margin[ch*6 +: 6]), 64'd32);
    tick();
    check({tag, " idle val"},  64'(dval), 64'd0);
    check({tag, " hold data"}, 64'(dout), 64'(base + 32'(n - 1)));
    check({tag, " hold id"},   64'(did),  64'(ch));
  endtask

  // Watchdog: no phase may hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q [3][$];
    logic [31:0] cur [3];
    logic [2:0]  acc;
    logic        saw_full;
    logic        has;
    int          idx;
    int          n;
    int          left;

    rstn     = 1'b1;
    ch_data  = '0;
    ch_valid = '0;
    s_data   = '0;
    s_valid  = '0;

    // ---------------- reset state ----------------
    tick();
    check("rst val",    64'(dval), 64'd0);
    check("rst data",   64'(dout), 64'd0);
    check("rst id",     64'(did),  64'd0);
    check("rst ready",  64'(ch_ready), 64'b111);
    check("rst margin", 64'(ch_margin), 64'({3{6'd32}}));
    check("rst small margin", 64'(s_margin), 64'd4);
    rstn = 1'b0;
    tick();
    check("post-rst idle val", 64'(dval), 64'd0);

    // ---------------- single channel stream (ch1, 100 words) ----------------
    stream(1, 32'h00C1_0000, 100, "ch1 stream");

    // ---------------- simultaneous push/pop (ch0 alone) ----------------
    stream(0, 32'h00C0_0000, 10, "ch0 push/pop");

    // ---------------- reset mid-stream ----------------
    // RR pointer is at ch0, so over 10 cycles of all-channel traffic each
    // channel is popped 3 times: 7 words stored, margin 25.
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 3; k++) ch_data[k*32 +: 32] = 32'h00D0_0000 + 32'(k * 256 + i);
      ch_valid = 3'b111;
      tick();
    end
    check("pre-rst margins", 64'(ch_margin), 64'({3{6'd25}}));
    rstn = 1'b1;
    #1;
    check("mid-rst val",    64'(dval), 64'd0);
    check("mid-rst ready",  64'(ch_ready), 64'b111);
    check("mid-rst margin", 64'(ch_margin), 64'({3{6'd32}}));
    check("mid-rst data",   64'(dout), 64'd0);
    check("mid-rst id",     64'(did),  64'd0);
    tick();
    check("held-rst val",    64'(dval), 64'd0);
    check("held-rst margin", 64'(ch_margin), 64'({3{6'd32}}));
    rstn     = 1'b0;
    ch_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no stale val",    64'(dval), 64'd0);
      check("no stale margin", 64'(ch_margin), 64'({3{6'd32}}));
    end

    // ---------------- round robin: 4 words per channel ----------------
    // Writes at P1..P4; words leave at P2..P13 in order ch0,ch1,ch2,...
    for (int m = 1; m <= 14; m++) begin
      if (m <= 4) begin
        for (int k = 0; k < 3; k++) ch_data[k*32 +: 32] = 32'h00A0_0000 | 32'(k << 8) | 32'(m - 1);
        ch_valid = 3'b111;
      end else begin
        ch_valid = 3'b000;
      end
      tick();
      if (m >= 2 && m <= 13) begin
        n = m - 2;
        check("rr val",  64'(dval), 64'd1);
        check("rr id",   64'(did),  64'(n % 3));
        check("rr data", 64'(dout), 64'(32'h00A0_0000 | 32'((n % 3) << 8) | 32'(n / 3)));
      end else begin
        check("rr idle val", 64'(dval), 64'd0);
      end
      if (m == 4) check("rr margins", 64'(ch_margin), 64'({3{6'd29}}));
    end

    // ---------------- fill to full, then drain through a scoreboard ----------------
    for (int k = 0; k < 3; k++) begin
      cur[k] = 32'h00F0_0000 | 32'(k << 16);
      ch_data[k*32 +: 32] = cur[k];
    end
    ch_valid = 3'b111;
    saw_full = 1'b0;
    for (int c = 0; c < 120; c++) begin
      acc = ch_valid & ch_ready;
      tick();
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) begin
          q[k].push_back(cur[k]);
          cur[k] = cur[k] + 32'd1;
          ch_data[k*32 +: 32] = cur[k];
        end
      end
      if (dval) begin
        idx = int'(did);
        has = (idx < 3) && (q[idx].size() > 0);
        check("full word expected", 64'(has), 64'd1);
        if (has) check("full order", 64'(dout), 64'(q[idx].pop_front()));
      end
      if (ch_margin[12 +: 6] == 6'd0) begin
        saw_full = 1'b1;
        check("full ready ch2", 64'(ch_ready[2]), 64'd0);
      end
    end
    check("ch2 reached full", 64'(saw_full), 64'd1);

    ch_valid = 3'b000;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (dval) begin
        idx = int'(did);
        has = (idx < 3) && (q[idx].size() > 0);
        check("drain word expected", 64'(has), 64'd1);
        if (has) check("drain order", 64'(dout), 64'(q[idx].pop_front()));
      end else if (q[0].size() + q[1].size() + q[2].size() == 0) begin
        break;
      end
    end
    left = q[0].size() + q[1].size() + q[2].size();
    check("drain words left", 64'(left), 64'd0);
    check("drain val",     64'(dval), 64'd0);
    check("drain margins", 64'(ch_margin), 64'({3{6'd32}}));

    // ---------------- N_CH=1, DW=8, DEPTH=4 instance ----------------
    for (int i = 0; i < 4; i++) begin
      s_data  = 8'h5A + 8'(i);
      s_valid = 1'b1;
      tick();
      check("small margin", 64'(s_margin), 64'd3);
      check("small ready",  64'(s_ready),  64'd1);
      if (i == 0) begin
        check("small first val", 64'(s_dval), 64'd0);
      end else begin
        check("small val",  64'(s_dval), 64'd1);
        check("small data", 64'(s_dout), 64'(8'h5A + 8'(i - 1)));
        check("small id",   64'(s_did),  64'd0);
      end
    end
    s_valid = 1'b0;
    tick();
    check("small last data", 64'(s_dout),   64'h5D);
    check("small margin 4",  64'(s_margin), 64'd4);
    tick();
    check("small idle val",  64'(s_dval), 64'd0);
    check("small hold data", 64'(s_dout), 64'h5D);
    check("small hold id",   64'(s_did),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
